peravg_ctrl: RTL and testbench

PERAVG_CTRL -- requirements
Module: peravg_ctrl

---
 rtl/peravg_pkg.sv | 26 ++
 rtl/peravg_if.sv | 31 +++
 rtl/peravg_ring.sv | 59 +++++
 rtl/peravg_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_peravg_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/peravg_pkg.sv
// Shared types for the tap-period averager: FSM encoding, reject constants, log2 helper.
// Imported by peravg_ctrl and peravg_ring.
package peravg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SUM   = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  localparam int MAX_PER_W = 64;
  localparam logic [MAX_PER_W-1:0] REJ_ZERO = '0;
  localparam logic [MAX_PER_W-1:0] REJ_ONES = '1;

  // Floor of log2; the caller turns it into the largest power of two <= v.
  function automatic int unsigned flog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (v >= (32'd1 << i)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/peravg_if.sv
// peravg_if: sample-in / average-out handshake bundle; peravg_ring_if: controller-to-ring bus.
// master drives the average (or the ring commands), slave is the opposite side.
interface peravg_if #(
  parameter int PER_W = 24
);
  logic [PER_W-1:0] btn_per;
  logic             btn_per_valid;
  logic [PER_W-1:0] per;
  logic             per_valid;
  logic             conv_ready;

  modport master (output per, per_valid, input btn_per, btn_per_valid, conv_ready);
  modport slave  (input per, per_valid, output btn_per, btn_per_valid, conv_ready);
endinterface

interface peravg_ring_if #(
  parameter int PER_W = 24,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [PER_W-1:0] wr_dat;
  logic             flush;
  logic             rd_next;
  logic [PER_W-1:0] rd_dat;
  logic [AW:0]      fill;

  modport master (output wr_en, wr_dat, flush, rd_next, input rd_dat, fill);
  modport slave  (input wr_en, wr_dat, flush, rd_next, output rd_dat, fill);
endinterface

// File: rtl/peravg_ring.sv
// Averaging ring buffer: write at wr_ptr, saturating fill count, newest-first read index.
// Read data is combinational from rd_idx; flush combined with a write stores the sample as sole entry.
module peravg_ring
  import peravg_pkg::*;
#(
  parameter int PER_W = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  peravg_ring_if.slave ring
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [PER_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [AW-1:0]    wr_idx;
  logic [FW-1:0]    fill_q, fill_d, fill_base;

  always_comb begin
    wr_idx    = ring.flush ? '0 : wr_ptr_q;
    fill_base = ring.flush ? '0 : fill_q;
    wr_ptr_d  = wr_idx;
    fill_d    = fill_base;
    rd_idx_d  = rd_idx_q;
    if (ring.wr_en) begin
      wr_ptr_d = wr_idx + AW'(1);
      fill_d   = (fill_base == FULL) ? FULL : fill_base + FW'(1);
      rd_idx_d = wr_idx;
    end else if (ring.rd_next) begin
      rd_idx_d = rd_idx_q - AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_idx_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_idx_q <= rd_idx_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is not reset: only fill decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (ring.wr_en) mem_q[wr_idx] <= ring.wr_dat;
  end

  assign ring.rd_dat = mem_q[rd_idx_q];
  assign ring.fill   = fill_q;

endmodule

// File: rtl/peravg_ctrl.sv
// Tap-period averager: per_valid_o rises N+2 cycles after a sample, held until conv_ready_i.
// Samples arriving while busy go to a one-entry pending slot. Optional: PERAVG_OUTLIER_EN.
module peravg_ctrl
  import peravg_pkg::*;
#(
  parameter int PER_W      = 24,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT_TP = 2_929_688
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tp_i,
  input  logic [PER_W-1:0]       btn_per_i,
  input  logic                   btn_per_valid_i,
  output logic [PER_W-1:0]       per_o,
  output logic                   per_valid_o,
  input  logic                   conv_ready_i,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int ACC_W = PER_W + AW;
  localparam int TW    = $clog2(TIMEOUT_TP + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TP);

  state_e           state_q, state_d;
  logic [PER_W-1:0] samp_q, samp_d;
  logic [PER_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    sum_cnt_q, sum_cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             rst_done_q, rst_done_d;
  logic             overrun_q, overrun_d;
  logic             take;
  logic             reject;
  logic             outlier;
  int unsigned      n_sh;
  logic [FW-1:0]    n_cnt;

  peravg_ring_if #(.PER_W(PER_W), .DEPTH(DEPTH)) ring_bus ();

  peravg_ring #(.PER_W(PER_W), .DEPTH(DEPTH)) u_ring (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ring   (ring_bus)
  );

  assign n_sh   = flog2(32'(ring_bus.fill));
  assign n_cnt  = FW'(32'd1 << n_sh);
  assign reject = (samp_q == REJ_ZERO[PER_W-1:0]) || (samp_q == REJ_ONES[PER_W-1:0]);
  // The first edge after reset release only arms rst_done_q; no sample is taken on it.
  assign take   = (state_q == ST_IDLE) && rst_done_q && (btn_per_valid_i || pend_vld_q);

`ifdef PERAVG_OUTLIER_EN
  logic [PER_W-1:0] last_avg_q, last_avg_d;
  logic [PER_W:0]   avg_ext, samp_ext, avg_lo, avg_hi;

  assign avg_ext  = {1'b0, last_avg_q};
  assign samp_ext = {1'b0, samp_q};
  assign avg_lo   = avg_ext - (avg_ext >> 1);
  assign avg_hi   = avg_ext + (avg_ext >> 1);
  assign outlier  = (ring_bus.fill != '0) && ((samp_ext < avg_lo) || (samp_ext > avg_hi));

  always_comb begin
    last_avg_d = last_avg_q;
    if (state_q == ST_ISSUE && conv_ready_i) last_avg_d = per_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_avg_q <= '0;
    else         last_avg_q <= last_avg_d;
  end
`else
  assign outlier = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    samp_d           = samp_q;
    pend_d           = pend_q;
    pend_vld_d       = pend_vld_q;
    acc_d            = acc_q;
    sum_cnt_d        = sum_cnt_q;
    per_d            = per_q;
    to_cnt_d         = to_cnt_q;
    rst_done_d       = 1'b1;
    overrun_d        = 1'b0;
    ring_bus.wr_en   = 1'b0;
    ring_bus.wr_dat  = samp_q;
    ring_bus.flush   = 1'b0;
    ring_bus.rd_next = 1'b0;

    // A sample on the timeout edge wins: the counter clears and no flush happens.
    if (btn_per_valid_i || take) begin
      to_cnt_d = '0;
    end else if (state_q == ST_IDLE && to_cnt_q == TO_MAX) begin
      to_cnt_d       = '0;
      ring_bus.flush = 1'b1;
    end else if (tp_i && to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (state_q != ST_IDLE && btn_per_valid_i) begin
      pend_d     = btn_per_i;
      pend_vld_d = 1'b1;
      overrun_d  = pend_vld_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          // The older pending sample goes first; a simultaneous new one refills the slot.
          if (pend_vld_q) begin
            samp_d     = pend_q;
            pend_d     = btn_per_i;
            pend_vld_d = btn_per_valid_i;
          end else begin
            samp_d = btn_per_i;
          end
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (reject) begin
          ring_bus.flush = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          ring_bus.flush = outlier;
          ring_bus.wr_en = 1'b1;
          acc_d          = '0;
          sum_cnt_d      = '0;
          state_d        = ST_SUM;
        end
      end
      ST_SUM: begin
        if (sum_cnt_q != n_cnt) begin
          acc_d            = acc_q + ACC_W'(ring_bus.rd_dat);
          sum_cnt_d        = sum_cnt_q + FW'(1);
          ring_bus.rd_next = 1'b1;
        end else begin
          per_d   = PER_W'(acc_q >> n_sh);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (conv_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      samp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      acc_q      <= '0;
      sum_cnt_q  <= '0;
      per_q      <= '0;
      to_cnt_q   <= '0;
      rst_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      acc_q      <= acc_d;
      sum_cnt_q  <= sum_cnt_d;
      per_q      <= per_d;
      to_cnt_q   <= to_cnt_d;
      rst_done_q <= rst_done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign per_o       = per_q;
  assign per_valid_o = (state_q == ST_ISSUE);
  assign fill_o      = ring_bus.fill;
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_peravg_ctrl.sv
// Directed bench for peravg_ctrl (DEPTH=4, PER_W=24, TIMEOUT_TP=4), hand-computed expectations.
module tb_peravg_ctrl;

  localparam int PER_W = 24;
  localparam int DEPTH = 4;
  localparam int TO_TP = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tp    = 1'b0;
  logic [2:0] fill;
  logic       busy;
  logic       overrun;
  int         checks = 0;
  int         errors = 0;

  peravg_if #(.PER_W(PER_W)) bus ();

  peravg_ctrl #(.PER_W(PER_W), .DEPTH(DEPTH), .TIMEOUT_TP(TO_TP)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .tp_i            (tp),
    .btn_per_i       (bus.btn_per),
    .btn_per_valid_i (bus.btn_per_valid),
    .per_o           (bus.per),
    .per_valid_o     (bus.per_valid),
    .conv_ready_i    (bus.conv_ready),
    .fill_o          (fill),
    .busy_o          (busy),
    .overrun_o       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    bus.btn_per       = 24'(v);
    bus.btn_per_valid = 1'b1;
    @(negedge clk);
    bus.btn_per_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.per_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("valid_seen", 32'(bus.per_valid), 1);
  endtask

  task automatic run(input int v, input int exp, input int n, input int f);
    int cyc;
    send(v);
    wait_valid(cyc);
    chk("latency", cyc, n + 2);
    chk("per_o", 32'(bus.per), exp);
    chk("fill_o", 32'(fill), f);
    @(negedge clk);
    chk("valid_drop", 32'(bus.per_valid), 0);
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      if (bus.per_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk(tag, 32'(seen), 0);
  endtask

  task automatic reject_run(input int v);
    send(v);
    quiet(6, "rej_no_valid");
    chk("rej_fill", 32'(fill), 0);
    chk("rej_busy", 32'(busy), 0);
  endtask

  task automatic tp_pulse();
    tp = 1'b1;
    @(negedge clk);
    tp = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.btn_per       = '0;
    bus.btn_per_valid = 1'b0;
    bus.conv_ready    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_per", 32'(bus.per), 0);
    chk("rst_valid", 32'(bus.per_valid), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Sample on the first edge after release must be ignored.
    rst_n = 1'b1;
    send(900);
    chk("first_edge_ignored", 32'(busy), 0);
    @(negedge clk);
    chk("first_edge_no_fill", 32'(fill), 0);

    run(1000, 1000, 1, 1);
    run(1200, 1100, 2, 2);
    run(1400, 1300, 2, 3);
    run(1600, 1300, 4, 4);

    // Backpressure: ready low for 10 ISSUE cycles, accepted on the 11th.
    bus.conv_ready = 1'b0;
    send(1800);
    wait_valid(cyc);
    chk("stall_latency", cyc, 6);
    chk("stall_per", 32'(bus.per), 1500);
    chk("fill_saturated", 32'(fill), 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid_held", 32'(bus.per_valid), 1);
      chk("stall_per_held", 32'(bus.per), 1500);
    end
    bus.conv_ready = 1'b1;
    @(negedge clk);
    chk("stall_valid_drop", 32'(bus.per_valid), 0);
    chk("stall_busy_drop", 32'(busy), 0);

    // Three samples in one run: second is overwritten by the third.
    send(2000);
    send(100);
    chk("no_overrun_first_pend", 32'(overrun), 0);
    send(2200);
    chk("overrun_pulse", 32'(overrun), 1);
    @(negedge clk);
    chk("overrun_one_cycle", 32'(overrun), 0);
    wait_valid(cyc);
    chk("first_of_three", 32'(bus.per), 1700);
    @(negedge clk);
    chk("between_outputs", 32'(bus.per_valid), 0);
    wait_valid(cyc);
    chk("pend_latency", cyc, 7);
    chk("third_of_three", 32'(bus.per), 1900);
    @(negedge clk);
    quiet(8, "no_output_for_second");
    chk("pend_drained_busy", 32'(busy), 0);

    // Timeout: three pulses keep the buffer, the fourth flushes it.
    repeat (3) tp_pulse();
    repeat (2) @(negedge clk);
    chk("to_below_limit_fill", 32'(fill), 4);
    tp_pulse();
    repeat (2) @(negedge clk);
    chk("to_flush_fill", 32'(fill), 0);

    run(300, 300, 1, 1);
    run(400, 350, 2, 2);
    run(500, 450, 2, 3);
    reject_run(0);

    run(300, 300, 1, 1);
    run(400, 350, 2, 2);
    run(500, 450, 2, 3);
    // Sample lands on the edge where the timeout would flush: buffer survives.
    repeat (3) tp_pulse();
    tp = 1'b1;
    @(negedge clk);
    tp = 1'b0;
    run(600, 450, 4, 4);

    reject_run(24'hFFFFFF);

    run(1000, 1000, 1, 1);
    run(1000, 1000, 2, 2);
    run(1000, 1000, 2, 3);
    run(1000, 1000, 4, 4);
`ifdef PERAVG_OUTLIER_EN
    run(2000, 2000, 1, 1);
`else
    run(2000, 1250, 4, 4);
`endif

    // Reset during SUM aborts without output.
    send(700);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midsum_rst_busy", 32'(busy), 0);
    chk("midsum_rst_valid", 32'(bus.per_valid), 0);
    repeat (2) @(negedge clk);
    chk("midsum_rst_fill", 32'(fill), 0);
    rst_n = 1'b1;
    quiet(6, "midsum_no_valid");
    run(500, 500, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
